// File: rtl/fdiv_meter.sv
// fdiv_meter: period and high-time meter for divided clocks.
// SIG_IN is synchronised into the CLK domain, its edges drive a four-state
// FSM that counts high and low cycles, and each completed period is
// published with a one-cycle VALID strobe plus deviation flags.
module fdiv_meter #(
  parameter int CW  = 16,
  parameter int TOL = 1
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          SIG_IN,
  input  logic          EN,
  input  logic [CW-1:0] EXP_PER,
  input  logic [CW-1:0] EXP_HI,
  output logic [CW-1:0] PER_OUT,
  output logic [CW-1:0] HI_OUT,
  output logic          VALID,
  output logic          PER_ERR,
  output logic          DUTY_ERR,
  output logic          OVF
);

  typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

  // All counter arithmetic runs one bit wider so saturation is visible.
  localparam logic [CW:0] MAX_W = {1'b0, {CW{1'b1}}};
  localparam logic [CW:0] ONE_W = (CW+1)'(1);
  localparam logic [CW:0] TOL_W = (CW+1)'(TOL);

  // Unsigned magnitude of the difference between two widened values.
  function automatic logic [CW:0] abs_diff(input logic [CW:0] a,
                                           input logic [CW:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // A deviation equal to TOL is still acceptable; only larger ones flag.
  function automatic logic dev_err(input logic [CW-1:0] meas,
                                   input logic [CW-1:0] expv);
    return abs_diff({1'b0, meas}, {1'b0, expv}) > TOL_W;
  endfunction

  // True when a widened count no longer fits in CW bits.
  function automatic logic sat(input logic [CW:0] v);
    return v > MAX_W;
  endfunction

  logic          s1, s2, s3;
  logic          rise, fall;
  state_t        state, state_nxt;
  logic [CW-1:0] hi_cnt, lo_cnt, hi_nxt, lo_nxt;
  logic [CW:0]   hi_inc, lo_inc, sum_cur, sum_inc;
  logic          pub, ovf_set;

  assign rise    = s2 & ~s3;
  assign fall    = ~s2 & s3;
  assign hi_inc  = {1'b0, hi_cnt} + ONE_W;
  assign lo_inc  = {1'b0, lo_cnt} + ONE_W;
  assign sum_cur = {1'b0, hi_cnt} + {1'b0, lo_cnt};
  assign sum_inc = sum_cur + ONE_W;

  // Two-flop synchroniser for SIG_IN plus a history flop for edge detection.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= SIG_IN;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Next-state, counter update, publish and saturation decisions.
  always_comb begin
    state_nxt = state;
    hi_nxt    = hi_cnt;
    lo_nxt    = lo_cnt;
    pub       = 1'b0;
    ovf_set   = 1'b0;
    if (!EN) begin
      state_nxt = IDLE;
      hi_nxt    = '0;
      lo_nxt    = '0;
    end else begin
      case (state)
        IDLE: begin
          // An edge seen in the first enabled cycle is deliberately ignored.
          state_nxt = ARM;
          hi_nxt    = '0;
          lo_nxt    = '0;
        end
        ARM: begin
          if (rise) begin
            state_nxt = HIGH;
            hi_nxt    = CW'(1);
            lo_nxt    = '0;
          end
        end
        HIGH: begin
          if (fall) begin
            if (sat(sum_inc)) begin
              ovf_set   = 1'b1;
              state_nxt = ARM;
              hi_nxt    = '0;
              lo_nxt    = '0;
            end else begin
              state_nxt = LOW;
              lo_nxt    = CW'(1);
            end
          end else if (sat(hi_inc)) begin
            ovf_set   = 1'b1;
            state_nxt = ARM;
            hi_nxt    = '0;
            lo_nxt    = '0;
          end else begin
            hi_nxt = hi_inc[CW-1:0];
          end
        end
        LOW: begin
          if (rise) begin
            // The running sum was kept in range by the LOW-phase checks.
            pub       = 1'b1;
            state_nxt = HIGH;
            hi_nxt    = CW'(1);
            lo_nxt    = '0;
          end else if (sat(lo_inc) || sat(sum_inc)) begin
            ovf_set   = 1'b1;
            state_nxt = ARM;
            hi_nxt    = '0;
            lo_nxt    = '0;
          end else begin
            lo_nxt = lo_inc[CW-1:0];
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FSM state and running counters.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= IDLE;
      hi_cnt <= '0;
      lo_cnt <= '0;
    end else begin
      state  <= state_nxt;
      hi_cnt <= hi_nxt;
      lo_cnt <= lo_nxt;
    end
  end

  // Result registers: updated only on publish, otherwise they hold.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      PER_OUT  <= '0;
      HI_OUT   <= '0;
      VALID    <= 1'b0;
      PER_ERR  <= 1'b0;
      DUTY_ERR <= 1'b0;
    end else begin
      VALID <= pub;
      if (pub) begin
        PER_OUT  <= sum_cur[CW-1:0];
        HI_OUT   <= hi_cnt;
        PER_ERR  <= dev_err(sum_cur[CW-1:0], EXP_PER);
        DUTY_ERR <= dev_err(hi_cnt, EXP_HI);
      end
    end
  end

  // Sticky overflow flag, cleared by reset or by disabling the meter.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      OVF <= 1'b0;
    end else if (!EN) begin
      OVF <= 1'b0;
    end else if (ovf_set) begin
      OVF <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fdiv_meter.sv
// Testbench for fdiv_meter: a CW=16 unit for the functional cases and a
// CW=4 unit for saturation. Expected publishes are queued as stimulus is
// issued and popped by an independent monitor whenever VALID is seen.
module tb_fdiv_meter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sig_a, en_a, valid_a, perr_a, derr_a, ovf_a;
  logic [15:0] exp_per_a, exp_hi_a, per_a, hi_a;
  logic        sig_b, en_b, valid_b, perr_b, derr_b, ovf_b;
  logic [3:0]  exp_per_b, exp_hi_b, per_b, hi_b;

  fdiv_meter #(.CW(16), .TOL(1)) dut_a (
    .CLK(clk), .RST_N(rst_n), .SIG_IN(sig_a), .EN(en_a),
    .EXP_PER(exp_per_a), .EXP_HI(exp_hi_a),
    .PER_OUT(per_a), .HI_OUT(hi_a), .VALID(valid_a),
    .PER_ERR(perr_a), .DUTY_ERR(derr_a), .OVF(ovf_a)
  );

  fdiv_meter #(.CW(4), .TOL(1)) dut_b (
    .CLK(clk), .RST_N(rst_n), .SIG_IN(sig_b), .EN(en_b),
    .EXP_PER(exp_per_b), .EXP_HI(exp_hi_b),
    .PER_OUT(per_b), .HI_OUT(hi_b), .VALID(valid_b),
    .PER_ERR(perr_b), .DUTY_ERR(derr_b), .OVF(ovf_b)
  );

  typedef struct {
    int unit;
    int per;
    int hi;
    int pe;
    int de;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   pcyc   = 0;

  // Pending (not yet published) period, published by the next rise.
  bit   have_pend = 1'b0;
  int   pend_h, pend_l, pend_pe, pend_de;

  always @(posedge clk) pcyc <= pcyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    n_chk++;
    if (act == expv) n_pass++;
    else $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, expv, $time);
  endtask

  task automatic set_sig(input int u, input logic v);
    if (u == 0) sig_a = v;
    else        sig_b = v;
  endtask

  task automatic hold(input int u, input logic v, input int n);
    repeat (n) begin
      @(negedge clk);
      set_sig(u, v);
    end
  endtask

  // Drive a rising edge; if a full period precedes it, expect its publish
  // three posedges after this drive.
  task automatic rise_edge(input int u);
    exp_t e;
    @(negedge clk);
    set_sig(u, 1'b1);
    if (have_pend) begin
      e.unit = u;
      e.per  = pend_h + pend_l;
      e.hi   = pend_h;
      e.pe   = pend_pe;
      e.de   = pend_de;
      e.cyc  = pcyc + 3;
      q.push_back(e);
    end
  endtask

  // One full synchronous period with hand-computed error flags.
  task automatic period(input int u, input int h, input int l,
                        input int pe, input int de);
    rise_edge(u);
    have_pend = 1'b1;
    pend_h    = h;
    pend_l    = l;
    pend_pe   = pe;
    pend_de   = de;
    hold(u, 1'b1, h - 1);
    hold(u, 1'b0, l);
  endtask

  task automatic check_pop(input int u, input int per, input int hi,
                           input int pe, input int de);
    exp_t e;
    if (q.size() == 0) begin
      chk("unexpected_valid", u + 1, 0);
    end else begin
      e = q.pop_front();
      chk("valid_unit", u, e.unit);
      chk("per_out", per, e.per);
      chk("hi_out", hi, e.hi);
      chk("per_err", pe, e.pe);
      chk("duty_err", de, e.de);
      chk("valid_latency", pcyc, e.cyc);
    end
  endtask

  // Monitor: compare every VALID strobe against the scoreboard.
  always @(negedge clk) begin
    if (valid_a === 1'b1) check_pop(0, int'(per_a), int'(hi_a), int'(perr_a), int'(derr_a));
    if (valid_b === 1'b1) check_pop(1, int'(per_b), int'(hi_b), int'(perr_b), int'(derr_b));
  end

  initial begin
    rst_n     = 1'b0;
    en_a      = 1'b0;
    en_b      = 1'b0;
    sig_a     = 1'b0;
    sig_b     = 1'b0;
    exp_per_a = 16'd10;
    exp_hi_a  = 16'd5;
    exp_per_b = 4'd6;
    exp_hi_b  = 4'd3;
    repeat (2) @(negedge clk);
    chk("rst_per_out", int'(per_a), 0);
    chk("rst_hi_out", int'(hi_a), 0);
    chk("rst_valid", int'(valid_a), 0);
    chk("rst_per_err", int'(perr_a), 0);
    chk("rst_duty_err", int'(derr_a), 0);
    chk("rst_ovf", int'(ovf_a), 0);

    @(negedge clk);
    rst_n = 1'b1;
    en_a  = 1'b1;
    hold(0, 1'b0, 3);

    // 5/5 nominal, then duty and period deviations around the tolerance.
    repeat (4) period(0, 5, 5, 0, 0);
    period(0, 6, 4, 0, 0);
    period(0, 7, 3, 0, 1);
    period(0, 6, 6, 1, 0);
    period(0, 5, 6, 0, 0);

    // Disable while high: the 5/6 period publishes, then the partial is lost.
    rise_edge(0);
    have_pend = 1'b0;
    hold(0, 1'b1, 3);
    @(negedge clk);
    en_a = 1'b0;
    hold(0, 1'b1, 4);
    chk("hold_per_out", int'(per_a), 11);
    chk("hold_hi_out", int'(hi_a), 5);
    chk("hold_per_err", int'(perr_a), 0);
    chk("hold_duty_err", int'(derr_a), 0);

    // Re-enable mid-high: the partial high must be discarded.
    @(negedge clk);
    en_a = 1'b1;
    hold(0, 1'b1, 2);
    hold(0, 1'b0, 4);
    period(0, 5, 5, 0, 0);
    period(0, 5, 5, 0, 0);

    // Publish the last 5/5, then reset asynchronously during the low phase.
    rise_edge(0);
    have_pend = 1'b0;
    hold(0, 1'b1, 4);
    hold(0, 1'b0, 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_per_out", int'(per_a), 0);
    chk("arst_hi_out", int'(hi_a), 0);
    chk("arst_valid", int'(valid_a), 0);
    chk("arst_per_err", int'(perr_a), 0);
    chk("arst_duty_err", int'(derr_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    hold(0, 1'b0, 3);
    period(0, 4, 4, 1, 0);
    period(0, 4, 4, 1, 0);
    rise_edge(0);
    have_pend = 1'b0;
    hold(0, 1'b1, 4);
    hold(0, 1'b0, 2);
    @(negedge clk);
    en_a = 1'b0;

    // Saturation on the 4-bit unit: stuck high after a rise.
    @(negedge clk);
    en_b = 1'b1;
    hold(1, 1'b0, 3);
    rise_edge(1);
    hold(1, 1'b1, 7);
    chk("ovf_before_sat", int'(ovf_b), 0);
    hold(1, 1'b1, 12);
    chk("ovf_after_sat", int'(ovf_b), 1);
    hold(1, 1'b0, 3);
    period(1, 3, 3, 0, 0);
    period(1, 3, 3, 0, 0);
    rise_edge(1);
    have_pend = 1'b0;
    hold(1, 1'b1, 4);
    hold(1, 1'b0, 2);
    chk("ovf_sticky", int'(ovf_b), 1);
    @(negedge clk);
    en_b = 1'b0;
    hold(1, 1'b0, 2);
    chk("ovf_clear_on_disable", int'(ovf_b), 0);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fdiv_meter.md
# fdiv_meter

Period and duty-cycle meter for the odd and half-integer divider outputs (e.g. 5-division `K_OR`, `K1`, `K2`). It sits directly downstream of the divider. It samples the divided signal with a faster measurement clock, counts high time and total period, and reports each completed period with a one-cycle valid strobe. It flags deviations from expected period and high time, so the 50%-duty claim of odd dividers can be checked on silicon and in simulation.

## Interface
- `CW`, 16: width of counters, expected values and results.
- `TOL`, 1: allowed absolute deviation in measurement-clock cycles before an error flag is raised.

- `CLK` in 1: measurement clock; must be faster than 2× the measured signal frequency.
- `RST_N` in 1: asynchronous, active-low reset.
- `SIG_IN` in 1: divided signal under test; asynchronous to `CLK`.
- `EN` in 1: measurement enable; level-sensitive.
- `EXP_PER` in CW: expected period in `CLK` cycles.
- `EXP_HI` in CW: expected high time in `CLK` cycles.
- `PER_OUT` out CW: last measured period.
- `HI_OUT` out CW: last measured high time.
- `VALID` out 1: one-cycle pulse when `PER_OUT`/`HI_OUT`/error flags update.
- `PER_ERR` out 1: \|PER_OUT−EXP_PER\| > TOL for last result.
- `DUTY_ERR` out 1: \|HI_OUT−EXP_HI\| > TOL for last result.
- `OVF` out 1: sticky counter saturation flag.

## Operation
- **Synchronizer and edge detection:**
  - `SIG_IN` passes through a 2-flop synchronizer (s1, s2) plus one history flop s3.
  - rise = s2 & ~s3; fall = ~s2 & s3.
- **FSM states:**
  - IDLE: entered while `EN`=0. Counters are cleared.
  - ARM: `EN`=1, waiting for the first rise. Any partial period before it is discarded.
  - HIGH: counting high cycles.
  - LOW: counting low cycles.
- **Transitions:**
  - IDLE→ARM when `EN`=1.
  - ARM→HIGH on rise: hi_cnt=1, lo_cnt=0.
  - HIGH→LOW on fall: lo_cnt=1, hi_cnt held.
  - LOW→HIGH on rise: results are published, then hi_cnt=1, lo_cnt=0.
  - In HIGH, non-fall cycles increment hi_cnt. In LOW, non-rise cycles increment lo_cnt.
  - Any state→IDLE when `EN`=0. This takes priority over every edge.
- **Publishing (LOW→HIGH transition only):**
  - `PER_OUT` ← hi_cnt+lo_cnt.
  - `HI_OUT` ← hi_cnt.
  - `PER_ERR` and `DUTY_ERR` are computed from those same new values.
  - `VALID`=1 for exactly one cycle.
  - Outputs hold between publishes. The first period after arming is published; the partial period before arming never is.
- **Arithmetic:**
  - Sum and differences are computed at CW+1 bits, unsigned magnitude.
  - A deviation exactly equal to TOL is not an error.
- **Saturation:**
  - If hi_cnt, lo_cnt, or hi_cnt+lo_cnt would exceed 2^CW−1, set `OVF`=1 and return to ARM with no publish.
  - `OVF` clears only on reset or `EN`=0.
- **Disable mid-measurement:** no publish; the partial measurement is discarded. `PER_OUT`/`HI_OUT`/error flags retain their last values.

## Timing
- **Reset values** (`RST_N`=0, immediate): `PER_OUT`=0, `HI_OUT`=0, `VALID`=0, `PER_ERR`=0, `DUTY_ERR`=0, `OVF`=0, FSM=IDLE, s1/s2/s3=0.
- **Latency:** `SIG_IN` first sampled high at `CLK` edge k → rise true in cycle after edge k+1 → `VALID` high after edge k+2, for one cycle.
- **Measured values:** identical to true high and low lengths for `CLK`-synchronous stimulus. Asynchronous stimulus may show ±1 per edge.
- **Minimum measurable high or low phase:** 1 cycle. Back-to-back rise/fall are handled without loss.
- **`EN` timing:**
  - `EN` rising at edge e: FSM is in ARM after e.
  - A rise already visible in the same cycle as `EN` first high is not taken. Counting starts on the next rise.
- **Reset release:** the first edge after `RST_N` deassertion behaves as a normal IDLE cycle.

## Test plan
- **5-division, 50% duty:** `CLK` at 2× divider clock, `SIG_IN` = `CLK`-synchronous 5 high / 5 low, `EXP_PER`=10, `EXP_HI`=5. Expect `VALID` every 10 cycles with `PER_OUT`=10, `HI_OUT`=5, `PER_ERR`=`DUTY_ERR`=0, first `VALID` 3 edges after the second rise.
- **Duty fault:** 6 high / 4 low, EXP 10/5, TOL=1 → `DUTY_ERR`=0 (dev 1). Then 7/3 → `HI_OUT`=7, `DUTY_ERR`=1, `PER_ERR`=0.
- **Period fault and boundary:** 6/6, EXP 10/5, TOL=1 → `PER_OUT`=12, `PER_ERR`=1. Then 5/6 → `PER_OUT`=11, `PER_ERR`=0.
- **Overflow:** CW=4, `SIG_IN` stuck high after a rise → `OVF`=1 after 15 high cycles, no `VALID`. Then a 3/3 waveform → `VALID` with `PER_OUT`=6 while `OVF` stays 1. `EN`=0 → `OVF`=0.
- **Disable mid-period:** drop `EN` during HIGH → no `VALID`, outputs hold. Re-enable mid-high → first partial period discarded, next full period reported correctly.
- **Async reset mid-measurement:** `RST_N` low during LOW → all outputs 0 immediately. After release with `EN`=1, measurement restarts from ARM.
